fifo_burst_drainer: RTL and testbench

Read-side controller for the asynchronous capture FIFO. It watches the FIFO's read-domain `empty`/`filled` flags and schedules bursts into the downstream memory writer. For each burst it issues one command (address, length), then pulls exactly that many words from the FIFO and streams them out through a 2-entry skid buffer that absorbs the FIFO's 1-cycle read latency. It lives entirely in the FIFO read clock domain and replaces the free-running `dequeue = !empty` pattern.

---
 rtl/fifo_burst_drainer.sv | 159 +++++++++++++++
 tb/tb_fifo_burst_drainer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_drainer.sv
// Read-side burst scheduler for the capture FIFO.
// Issues (addr,len) commands, then streams len words via a 2-entry skid.
module fifo_burst_drainer #(
  parameter int DATA_W      = 8,
  parameter int BURST_LEN   = 16,
  parameter int ADDR_W      = 20,
  parameter int FRAME_WORDS = 307200,
  parameter int LEN_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic              fifo_filled,
  output logic              fifo_dequeue,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              frame_start,
  input  logic              flush,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done
);
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  localparam logic [ADDR_W:0] LP_FW  = (ADDR_W+1)'(FRAME_WORDS);
  localparam logic [LEN_W-1:0] LP_BL = LEN_W'(BURST_LEN);
  localparam logic [LEN_W-1:0] LP_L1 = LEN_W'(1);
  localparam logic [LEN_W:0]  LP_ONE = (LEN_W+1)'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W:0]    r_issued;
  logic [LEN_W:0]    r_sent;
  logic [1:0]        r_occ;
  logic [DATA_W-1:0] r_sk0;
  logic [DATA_W-1:0] r_sk1;
  logic              r_inflight;
  logic              r_fs_pend;
  logic              r_fl_pend;
  logic              r_frame_done;

  logic              w_pop;
  logic              w_deq;
  logic              w_last;
  logic [1:0]        w_fill;
  logic [ADDR_W:0]   w_next;

  // occ+inflight never exceeds 2, and pop implies occ>=1
  assign w_pop  = (r_occ != 2'd0) && wr_ready;
  assign w_fill = r_occ + {1'b0, r_inflight}
                - {1'b0, w_pop};
  assign w_deq  = (r_state == DATA)
               && (r_issued < {1'b0, r_len})
               && !fifo_empty
               && (w_fill < 2'd2);
  assign w_last = w_pop
               && (r_sent == ({1'b0, r_len} - LP_ONE));
  assign w_next = {1'b0, r_addr}
                + (ADDR_W+1)'(r_len);

  assign fifo_dequeue = w_deq;
  assign cmd_valid    = (r_state == CMD);
  assign cmd_addr     = r_addr;
  assign cmd_len      = r_len;
  assign wr_valid     = (r_occ != 2'd0);
  assign wr_data      = r_sk0;
  assign busy         = (r_state != IDLE)
                     || (r_occ != 2'd0);
  assign frame_done   = r_frame_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_len        <= '0;
      r_issued     <= '0;
      r_sent       <= '0;
      r_fs_pend    <= 1'b0;
      r_fl_pend    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (r_fs_pend) begin
            r_addr    <= '0;
            r_fs_pend <= 1'b0;
          end else if (fifo_filled) begin
            r_len   <= LP_BL;
            r_state <= CMD;
          end else if (r_fl_pend && !fifo_empty) begin
            r_len   <= LP_L1;
            r_state <= CMD;
          end else if (r_fl_pend) begin
            r_fl_pend <= 1'b0;
          end
        end
        CMD: begin
          if (cmd_ready) begin
            r_state  <= DATA;
            r_issued <= '0;
            r_sent   <= '0;
          end
        end
        DATA: begin
          if (w_deq) r_issued <= r_issued + LP_ONE;
          if (w_pop) r_sent <= r_sent + LP_ONE;
          if (w_last) begin
            r_state <= IDLE;
            if (w_next >= LP_FW) begin
              r_addr       <= '0;
              r_frame_done <= 1'b1;
            end else begin
              r_addr <= w_next[ADDR_W-1:0];
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      // a new pulse wins over a same-cycle clear
      if (frame_start) r_fs_pend <= 1'b1;
      if (flush) r_fl_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ      <= '0;
      r_sk0      <= '0;
      r_sk1      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_deq;
      r_occ      <= w_fill;
      if (r_inflight) begin
        if (w_pop) begin
          if (r_occ == 2'd2) begin
            r_sk0 <= r_sk1;
            r_sk1 <= fifo_rdata;
          end else begin
            r_sk0 <= fifo_rdata;
          end
        end else if (r_occ == 2'd0) begin
          r_sk0 <= fifo_rdata;
        end else begin
          r_sk1 <= fifo_rdata;
        end
      end else if (w_pop) begin
        r_sk0 <= r_sk1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_burst_drainer.sv
// Scoreboard bench for fifo_burst_drainer with a queue-based FIFO model.
// Commands and data are queued when stimulus is loaded, checked on handshake.
module tb_fifo_burst_drainer;
  localparam int DW = 8;
  localparam int BL = 16;
  localparam int AW = 20;
  localparam int FW = 32;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifo_empty;
  logic          fifo_filled;
  logic          fifo_dequeue;
  logic [DW-1:0] fifo_rdata = '0;
  logic          frame_start = 1'b0;
  logic          flush = 1'b0;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid;
  logic          wr_ready = 1'b0;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          frame_done;

  fifo_burst_drainer #(
    .DATA_W(DW), .BURST_LEN(BL), .ADDR_W(AW),
    .FRAME_WORDS(FW), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_filled(fifo_filled),
    .fifo_dequeue(fifo_dequeue),
    .fifo_rdata(fifo_rdata),
    .frame_start(frame_start),
    .flush(flush),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data(wr_data),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq[$];
  int            fcnt = 0;
  assign fifo_empty  = (fcnt == 0);
  assign fifo_filled = (fcnt >= BL);

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int deqs = 0;
  int pops = 0;
  int fd_cnt = 0;
  int fd_cyc = 0;
  int hs_cyc = 0;
  int fp_cyc = 0;
  int lp_cyc = 0;
  bit first_pend = 1'b0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] exp_d[$];
  int exp_a[$];
  int exp_l[$];
  int exp_addr = 0;
  logic [DW-1:0] nxt_val = 8'h01;
  int ea;
  int el;
  logic [DW-1:0] ed;

  // FIFO model: read data appears the cycle after the strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_dequeue && fq.size() > 0)
      fifo_rdata <= fq.pop_front();
    fcnt <= fq.size();
  end

  always @(negedge clk) if (!rst) begin
    if (fifo_dequeue) begin
      deqs++;
      n_total++;
      if (fifo_empty !== 1'b0)
        $display("FAIL deq_when_empty got=1 want=0");
      else n_pass++;
    end
    if (prev_stall) begin
      n_total++;
      if (wr_valid !== 1'b1 || wr_data !== prev_data)
        $display("FAIL stall_hold got=%0b/%h want=1/%h",
                 wr_valid, wr_data, prev_data);
      else n_pass++;
    end
    if (cmd_valid && cmd_ready) begin
      n_total++;
      if (exp_a.size() == 0) begin
        $display("FAIL cmd_unexpected got=%0d/%0d want=none",
                 cmd_addr, cmd_len);
      end else begin
        ea = exp_a.pop_front();
        el = exp_l.pop_front();
        if (cmd_addr !== AW'(ea) || cmd_len !== LW'(el))
          $display("FAIL cmd got=%0d/%0d want=%0d/%0d",
                   cmd_addr, cmd_len, ea, el);
        else n_pass++;
      end
      hs_cyc = cyc;
      first_pend = 1'b1;
    end
    if (wr_valid && wr_ready) begin
      pops++;
      if (first_pend) begin
        fp_cyc = cyc;
        first_pend = 1'b0;
      end
      lp_cyc = cyc;
      n_total++;
      if (exp_d.size() == 0) begin
        $display("FAIL data_unexpected got=%h want=none",
                 wr_data);
      end else begin
        ed = exp_d.pop_front();
        if (wr_data !== ed)
          $display("FAIL data got=%h want=%h", wr_data, ed);
        else n_pass++;
      end
    end
    if (fifo_dequeue) begin
      n_total++;
      if (deqs - pops > 2)
        $display("FAIL outstanding got=%0d want<=2",
                 deqs - pops);
      else n_pass++;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    prev_stall = wr_valid && !wr_ready;
    prev_data  = wr_data;
  end

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(nxt_val);
      exp_d.push_back(nxt_val);
      nxt_val = nxt_val + 8'h01;
    end
  endtask

  task automatic exp_cmd(input int len);
    exp_a.push_back(exp_addr);
    exp_l.push_back(len);
    if (exp_addr + len >= FW) exp_addr = 0;
    else exp_addr = exp_addr + len;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k = 0;
    while ((exp_d.size() != 0 || exp_a.size() != 0 ||
            busy || fcnt != 0) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    n_total++;
    if (k >= budget)
      $display("FAIL %s_timeout got=%0d want<%0d",
               nm, k, budget);
    else n_pass++;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #20;
    n_total++;
    if ({cmd_valid, wr_valid, fifo_dequeue,
         frame_done, busy} !== 5'b0)
      $display("FAIL rst_ctl got=%b want=00000",
               {cmd_valid, wr_valid, fifo_dequeue,
                frame_done, busy});
    else n_pass++;
    n_total++;
    if (cmd_addr !== '0 || cmd_len !== '0 || wr_data !== '0)
      $display("FAIL rst_data got=%0d/%0d/%h want=0/0/00",
               cmd_addr, cmd_len, wr_data);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_burst;
    int d0;
    cmd_ready = 1'b1;
    wr_ready  = 1'b1;
    nxt_val   = 8'h01;
    d0 = deqs;
    exp_cmd(BL);
    load(BL);
    wait_done("single", 200);
    n_total++;
    if (fp_cyc - hs_cyc !== 3)
      $display("FAIL first_latency got=%0d want=3",
               fp_cyc - hs_cyc);
    else n_pass++;
    n_total++;
    if (lp_cyc - fp_cyc !== BL - 1)
      $display("FAIL sustained got=%0d want=%0d",
               lp_cyc - fp_cyc, BL - 1);
    else n_pass++;
    n_total++;
    if (deqs - d0 !== BL)
      $display("FAIL deq_count got=%0d want=%0d",
               deqs - d0, BL);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    int pat[4] = '{1, 0, 0, 1};
    int k = 0;
    int f0 = fd_cnt;
    nxt_val = 8'h01;
    exp_cmd(BL);
    load(BL);
    while ((exp_d.size() != 0 || busy || fcnt != 0)
           && k < 400) begin
      @(posedge clk); #1;
      wr_ready = pat[k % 4][0];
      k++;
    end
    wr_ready = 1'b1;
    n_total++;
    if (k >= 400)
      $display("FAIL bp_timeout got=%0d want<400", k);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (fd_cnt - f0 !== 1 || fd_cyc !== lp_cyc + 1)
      $display("FAIL bp_wrap got=%0d@%0d want=1@%0d",
               fd_cnt - f0, fd_cyc, lp_cyc + 1);
    else n_pass++;
  endtask

  task automatic test_frame_wrap;
    int f0 = fd_cnt;
    repeat (3) exp_cmd(BL);
    load(3 * BL);
    wait_done("wrap", 400);
    n_total++;
    if (fd_cnt - f0 !== 1)
      $display("FAIL wrap_pulses got=%0d want=1",
               fd_cnt - f0);
    else n_pass++;
    n_total++;
    if (!(fd_cyc < hs_cyc))
      $display("FAIL wrap_when got=%0d want<%0d",
               fd_cyc, hs_cyc);
    else n_pass++;
  endtask

  task automatic test_cmd_stall;
    int d0;
    int a0 = exp_addr;
    int k = 0;
    cmd_ready = 1'b0;
    exp_cmd(BL);
    load(BL);
    while (!cmd_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    d0 = deqs;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (cmd_valid !== 1'b1 || cmd_addr !== AW'(a0) ||
          cmd_len !== LW'(BL) || fifo_dequeue !== 1'b0)
        $display("FAIL stall_cmd got=%0b/%0d/%0d/%0b want=1/%0d/%0d/0",
                 cmd_valid, cmd_addr, cmd_len,
                 fifo_dequeue, a0, BL);
      else n_pass++;
    end
    n_total++;
    if (deqs !== d0)
      $display("FAIL stall_deq got=%0d want=0", deqs - d0);
    else n_pass++;
    cmd_ready = 1'b1;
    wait_done("stall", 200);
  endtask

  task automatic test_flush;
    repeat (3) exp_cmd(1);
    load(3);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_done("flush", 200);
    repeat (5) @(posedge clk);
    #1;
    n_total++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0 || fcnt !== 0)
      $display("FAIL flush_end got=%0b/%0b/%0d want=0/0/0",
               busy, cmd_valid, fcnt);
    else n_pass++;
  endtask

  task automatic test_frame_start;
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_addr = 0;
    exp_cmd(BL);
    load(BL);
    wait_done("fstart", 200);
  endtask

  task automatic test_reset_mid;
    int k = 0;
    exp_cmd(BL);
    wr_ready = 1'b0;
    load(BL);
    while ((deqs - pops) < 2 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    n_total++;
    if (k >= 40)
      $display("FAIL rm_fill_timeout got=%0d want<40", k);
    else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({cmd_valid, wr_valid, fifo_dequeue, frame_done,
         busy} !== 5'b0 || cmd_addr !== '0 || wr_data !== '0)
      $display("FAIL rst_mid got=%b/%0d/%h want=00000/0/00",
               {cmd_valid, wr_valid, fifo_dequeue,
                frame_done, busy}, cmd_addr, wr_data);
    else n_pass++;
    fq.delete();
    exp_d.delete();
    exp_a.delete();
    exp_l.delete();
    pops = deqs;
    prev_stall = 1'b0;
    first_pend = 1'b0;
    exp_addr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wr_ready = 1'b1;
    exp_cmd(BL);
    load(BL);
    wait_done("after_rst", 200);
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_backpressure();
    test_frame_wrap();
    test_cmd_stall();
    test_flush();
    test_frame_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
